// File: rtl/controle_varredura_if.sv
// rtl/controle_varredura_if.sv - handshake and status bundle between the sweep controller and its environment
interface controle_varredura_if;
    logic       ligar;
    logic       medida_pronta;
    logic [4:0] posicao;
    logic       medir;
    logic       sentido;
    logic       fim_varredura;
    logic       erro_medida;
    logic [2:0] db_estado;

    // Environment side: enables the sweep and acknowledges measurements.
    modport master (
        output ligar,
        output medida_pronta,
        input  posicao,
        input  medir,
        input  sentido,
        input  fim_varredura,
        input  erro_medida,
        input  db_estado
    );

    // Controller side.
    modport slave (
        input  ligar,
        input  medida_pronta,
        output posicao,
        output medir,
        output sentido,
        output fim_varredura,
        output erro_medida,
        output db_estado
    );
endinterface

// File: rtl/controle_varredura.sv
// rtl/controle_varredura.sv - ping-pong servo sweep sequencer; optional measurement timeout under TIMEOUT_MEDIDA_EN
module controle_varredura #(
    parameter int unsigned T_ASSENTA = 32'd25000000,
    parameter int unsigned T_TIMEOUT = 32'd5000000,
    parameter int unsigned POS_MAX   = 32'd28
) (
    input  logic                  clock,
    input  logic                  reset,
    controle_varredura_if.slave   bus
);

    typedef enum logic [2:0] {
        PARADO  = 3'd0,
        ASSENTA = 3'd1,
        PEDE    = 3'd2,
        ESPERA  = 3'd3,
        AVANCA  = 3'd4
    } estado_t;

    // Last settle-counter value before the measurement request.
    localparam logic [31:0] ASSENTA_FIM = 32'(T_ASSENTA - 32'd1);
    localparam logic [4:0]  P_MAX       = 5'(POS_MAX);
    localparam logic [4:0]  P_PENULT    = 5'(POS_MAX - 32'd1);

    // Parameter legality: an out-of-range set elaborates this empty scope, easy to spot in a hierarchy dump.
    if (T_ASSENTA == 0 || T_TIMEOUT == 0 || POS_MAX < 1 || POS_MAX > 28) begin : g_parametros_invalidos
    end

    estado_t     estado;
    logic [4:0]  posicao_q;
    logic        sentido_q;
    logic        medir_q;
    logic        fim_q;
    logic [31:0] cnt_assenta;

    logic [4:0]  pos_prox;
    logic        sent_prox;
    logic        extremo;

`ifdef TIMEOUT_MEDIDA_EN
    localparam logic [31:0] TIMEOUT_FIM = 32'(T_TIMEOUT - 32'd1);
    logic [31:0] cnt_espera;
    logic        erro_q;
`endif

    // Next ping-pong position: reaching an endpoint reverses direction and flags the end of a sweep.
    always_comb begin
        pos_prox  = posicao_q;
        sent_prox = sentido_q;
        extremo   = 1'b0;
        if (sentido_q) begin
            if (posicao_q < P_PENULT) begin
                pos_prox = posicao_q + 5'd1;
            end else begin
                pos_prox  = P_MAX;
                sent_prox = 1'b0;
                extremo   = 1'b1;
            end
        end else begin
            if (posicao_q > 5'd1) begin
                pos_prox = posicao_q - 5'd1;
            end else begin
                pos_prox  = 5'd0;
                sent_prox = 1'b1;
                extremo   = 1'b1;
            end
        end
    end

    // Sweep sequencer: state, saturating counters, position/direction and single-cycle registered pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= PARADO;
            posicao_q   <= 5'd0;
            sentido_q   <= 1'b1;
            medir_q     <= 1'b0;
            fim_q       <= 1'b0;
            cnt_assenta <= 32'd0;
`ifdef TIMEOUT_MEDIDA_EN
            cnt_espera  <= 32'd0;
            erro_q      <= 1'b0;
`endif
        end else begin
            // Pulses default low so none can last more than one cycle.
            medir_q <= 1'b0;
            fim_q   <= 1'b0;
`ifdef TIMEOUT_MEDIDA_EN
            erro_q  <= 1'b0;
`endif
            if (!bus.ligar) begin
                // Disable wins over everything, including a same-cycle acknowledge; position and direction hold.
                estado <= PARADO;
            end else begin
                case (estado)
                    PARADO: begin
                        cnt_assenta <= 32'd0;
                        estado      <= ASSENTA;
                    end
                    ASSENTA: begin
                        if (cnt_assenta >= ASSENTA_FIM) begin
                            estado  <= PEDE;
                            medir_q <= 1'b1;
                        end else if (cnt_assenta != 32'hFFFF_FFFF) begin
                            cnt_assenta <= cnt_assenta + 32'd1;
                        end
                    end
                    PEDE: begin
`ifdef TIMEOUT_MEDIDA_EN
                        cnt_espera <= 32'd0;
`endif
                        estado     <= ESPERA;
                    end
                    ESPERA: begin
                        // An acknowledge on the timeout cycle counts as a normal acknowledge.
                        if (bus.medida_pronta) begin
                            estado <= AVANCA;
`ifdef TIMEOUT_MEDIDA_EN
                        end else if (cnt_espera >= TIMEOUT_FIM) begin
                            erro_q <= 1'b1;
                            estado <= AVANCA;
                        end else if (cnt_espera != 32'hFFFF_FFFF) begin
                            cnt_espera <= cnt_espera + 32'd1;
`endif
                        end
                    end
                    AVANCA: begin
                        posicao_q   <= pos_prox;
                        sentido_q   <= sent_prox;
                        fim_q       <= extremo;
                        cnt_assenta <= 32'd0;
                        estado      <= ASSENTA;
                    end
                    default: begin
                        estado <= PARADO;
                    end
                endcase
            end
        end
    end

    assign bus.posicao       = posicao_q;
    assign bus.sentido       = sentido_q;
    assign bus.medir         = medir_q;
    assign bus.fim_varredura = fim_q;
    assign bus.db_estado     = estado;

`ifdef TIMEOUT_MEDIDA_EN
    assign bus.erro_medida   = erro_q;
`else
    assign bus.erro_medida   = 1'b0;
`endif

endmodule

// File: tb/tb_controle_varredura.sv
// tb/tb_controle_varredura.sv - scoreboard bench for controle_varredura with a ping-pong reference model
module tb_controle_varredura;

    localparam int TA = 4;
    localparam int PM = 3;
    localparam int TT = 6;

    typedef struct {
        int p;
        int s;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    controle_varredura_if bus ();

    controle_varredura #(
        .T_ASSENTA (TA),
        .T_TIMEOUT (TT),
        .POS_MAX   (PM)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   k      = 0;
    exp_t q_medir[$];
    int   q_fim[$];
    int   q_erro[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Reference model: after k completed steps the sweep sits on a triangle wave of period 2*PM.
    function automatic int pos_of(input int step);
        int m;
        m = step % (2 * PM);
        return (m <= PM) ? m : (2 * PM - m);
    endfunction

    function automatic int dir_of(input int step);
        return ((step % (2 * PM)) < PM) ? 1 : 0;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a pulse.
    int   cyc    = 0;
    int   av_cyc = 0;
    bit   av_ok  = 1'b0;
    logic p_medir = 1'b0, p_fim = 1'b0, p_erro = 1'b0;
    exp_t em;
    int   ef;

    always @(negedge clock) begin
        cyc++;
        if (bus.medir === 1'b1) begin
            check("medir_not_consecutive", p_medir, 0);
            if (q_medir.size() == 0) begin
                check("medir_unexpected", bus.medir, 0);
            end else begin
                em = q_medir.pop_front();
                check("medir_posicao", bus.posicao, em.p);
                check("medir_sentido", bus.sentido, em.s);
            end
            if (av_ok) check("avanca_to_medir_cycles", cyc - av_cyc, 5);
            av_ok = 1'b0;
        end
        if (bus.fim_varredura === 1'b1) begin
            check("fim_not_consecutive", p_fim, 0);
            if (q_fim.size() == 0) begin
                check("fim_unexpected", bus.fim_varredura, 0);
            end else begin
                ef = q_fim.pop_front();
                check("fim_posicao", bus.posicao, ef);
            end
        end
        if (bus.erro_medida === 1'b1) begin
            check("erro_not_consecutive", p_erro, 0);
            if (q_erro.size() == 0) begin
                check("erro_unexpected", bus.erro_medida, 0);
            end else begin
                ef = q_erro.pop_front();
                check("erro_posicao", bus.posicao, ef);
            end
        end
        p_medir = bus.medir;
        p_fim   = bus.fim_varredura;
        p_erro  = bus.erro_medida;
        if (bus.db_estado === 3'd4) begin
            av_cyc = cyc;
            av_ok  = 1'b1;
        end
        if (reset !== 1'b1 || bus.ligar !== 1'b1) av_ok = 1'b0;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_medir();
        exp_t e;
        e.p = pos_of(k);
        e.s = dir_of(k);
        q_medir.push_back(e);
    endtask

    task automatic advance();
        k++;
        if (pos_of(k) == 0 || pos_of(k) == PM) q_fim.push_back(pos_of(k));
        push_medir();
    endtask

    task automatic wait_medir(output int n);
        n = 0;
        while (bus.medir !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("medir_arrives", bus.medir, 1);
    endtask

    task automatic check_drop();
        check("drop_parado", bus.db_estado, 0);
        check("drop_posicao_held", bus.posicao, pos_of(k));
        check("drop_sentido_held", bus.sentido, dir_of(k));
        check("drop_no_pulses", {bus.medir, bus.fim_varredura, bus.erro_medida}, 0);
    endtask

    task automatic resume();
        int n;
        repeat ($urandom_range(1, 3)) tick();
        bus.ligar = 1'b1;
        wait_medir(n);
        check("resume_settle_cycles", n, 5);
    endtask

    // Ack in ESPERA cycle d; optionally a stray ack during PEDE first, which must be ignored.
    task automatic step_ack(input int d, input bit spur);
        int n;
        int rest;
        wait_medir(n);
        rest = d;
        if (spur) begin
            bus.medida_pronta = 1'b1;
            tick();
            bus.medida_pronta = 1'b0;
            check("pede_ack_ignored", bus.db_estado, 3);
            rest = d - 1;
        end
        repeat (rest) tick();
        bus.medida_pronta = 1'b1;
        advance();
        tick();
        bus.medida_pronta = 1'b0;
    endtask

    task automatic drop_espera(input bit with_ack);
        int n;
        wait_medir(n);
        tick();
        check("in_espera", bus.db_estado, 3);
        if (with_ack) bus.medida_pronta = 1'b1;
        bus.ligar = 1'b0;
        tick();
        bus.medida_pronta = 1'b0;
        check_drop();
        push_medir();
        resume();
    endtask

    task automatic drop_assenta(input int d);
        int n;
        step_ack(d, 1'b0);
        n = 0;
        while (bus.db_estado !== 3'd1 && n < 20) begin
            tick();
            n++;
        end
        check("assenta_reached", bus.db_estado, 1);
        repeat ($urandom_range(0, 2)) tick();
        bus.ligar = 1'b0;
        tick();
        check_drop();
        resume();
    endtask

    task automatic no_ack();
        int n;
        wait_medir(n);
`ifdef TIMEOUT_MEDIDA_EN
        q_erro.push_back(pos_of(k));
        n = 0;
        while (bus.erro_medida !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("timeout_latency", n, 7);
        advance();
`else
        repeat (100) begin
            tick();
            check("espera_indefinite", {bus.db_estado, bus.erro_medida}, 4'b0110);
        end
        bus.ligar = 1'b0;
        tick();
        check_drop();
        push_medir();
        resume();
`endif
    endtask

    function automatic int max_delay();
`ifdef TIMEOUT_MEDIDA_EN
        return TT;
`else
        return TT + 2;
`endif
    endfunction

    initial begin
        int n;
        bus.ligar         = 1'b0;
        bus.medida_pronta = 1'b0;
        reset             = 1'b0;
        repeat (3) tick();
        check("rst_posicao", bus.posicao, 0);
        check("rst_sentido", bus.sentido, 1);
        check("rst_medir", bus.medir, 0);
        check("rst_fim", bus.fim_varredura, 0);
        check("rst_erro", bus.erro_medida, 0);
        check("rst_db_estado", bus.db_estado, 0);
        reset = 1'b1;
        repeat (2) tick();
        check("idle_without_ligar", bus.db_estado, 0);

        // Steady sweep with a fixed ack two cycles into ESPERA.
        bus.ligar = 1'b1;
        push_medir();
        wait_medir(n);
        check("first_settle_cycles", n, 5);
        for (int i = 0; i < 8; i++) step_ack(2, 1'b0);

        // Drop ligar while settling at position 2.
        while (pos_of(k + 1) != 2) step_ack(2, 1'b0);
        drop_assenta(2);

        // Ack exactly on the timeout cycle.
        step_ack(TT, 1'b0);

        // Continuous ack: one advance per step.
        bus.medida_pronta = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_medir(n);
            advance();
            tick();
            tick();
            check("held_ack_single_advance", bus.db_estado, 4);
        end
        bus.medida_pronta = 1'b0;

        // No ack at all.
        no_ack();

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0, 1, 2: step_ack($urandom_range(1, max_delay()), 1'($urandom_range(0, 1)));
                3:       drop_espera(1'($urandom_range(0, 1)));
                4:       drop_assenta($urandom_range(1, 3));
                5:       no_ack();
                default: step_ack(1, 1'b0);
            endcase
        end

        // Asynchronous reset in ESPERA at the top endpoint.
        while (pos_of(k) != PM) step_ack(1, 1'b0);
        wait_medir(n);
        tick();
        check("reset_in_espera", bus.db_estado, 3);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_posicao", bus.posicao, 0);
        check("async_rst_sentido", bus.sentido, 1);
        check("async_rst_medir", bus.medir, 0);
        check("async_rst_fim", bus.fim_varredura, 0);
        check("async_rst_erro", bus.erro_medida, 0);
        check("async_rst_db_estado", bus.db_estado, 0);
        q_medir.delete();
        q_fim.delete();
        q_erro.delete();
        k = 0;
        tick();
        reset = 1'b1;
        push_medir();
        for (int i = 0; i < 4; i++) step_ack($urandom_range(1, max_delay()), 1'b0);

        bus.ligar = 1'b0;
        repeat (3) tick();
        check("pending_medir", q_medir.size(), 1);
        check("pending_fim", q_fim.size(), 0);
        check("pending_erro", q_erro.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/controle_varredura.md
CONTROLE_VARREDURA -- requirements
Module: controle_varredura

Interface
REQ-001 Parameter T_ASSENTA, default 25000000, servo settle time in clock cycles per position (500 ms at 50 MHz); legal range 1..2^32-1.
REQ-002 Parameter T_TIMEOUT, default 5000000, maximum measurement wait in cycles; legal range 1..2^32-1.
REQ-003 Parameter POS_MAX, default 28, highest sweep position code; legal range 1..28.
REQ-004 clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ligar  input  1  sweep enable, level-sensitive.
REQ-007 medida_pronta  input  1  sensor acknowledge, one-cycle pulse or level.
REQ-008 posicao  output  5  position code driven to the servo PWM generator; registered.
REQ-009 medir  output  1  measurement request, one-cycle pulse.
REQ-010 sentido  output  1  sweep direction: 1 = increasing, 0 = decreasing.
REQ-011 fim_varredura  output  1  one-cycle pulse when an endpoint (0 or POS_MAX) is reached.
REQ-012 erro_medida  output  1  one-cycle pulse on measurement timeout.
REQ-013 db_estado  output  3  current FSM state encoding, for debug.

Function
REQ-014 The FSM SHALL use these states and encodings: PARADO=0, ASSENTA=1, PEDE=2, ESPERA=3, AVANCA=4.
REQ-015 PARADO SHALL go to ASSENTA when ligar=1 and reload the settle counter to 0.
REQ-016 ASSENTA SHALL count cycles and, on reaching count T_ASSENTA-1, go to PEDE; posicao SHALL be stable for the whole of ASSENTA.
REQ-017 PEDE SHALL assert medir for exactly one cycle, clear the timeout counter, and go to ESPERA.
REQ-018 ESPERA SHALL go to AVANCA on the first cycle medida_pronta=1; a medida_pronta sampled outside ESPERA SHALL be ignored.
REQ-019 AVANCA SHALL update posicao and sentido, clear the settle counter, and return to ASSENTA after one cycle.
REQ-020 Ping-pong rule for sentido=1: if posicao<POS_MAX-1, posicao+1; if posicao=POS_MAX-1, set posicao=POS_MAX, set sentido=0, and pulse fim_varredura.
REQ-021 Ping-pong rule for sentido=0: if posicao>1, posicao-1; if posicao=1, set posicao=0, set sentido=1, and pulse fim_varredura.
REQ-022 Boundary case: with POS_MAX=1, the sweep SHALL alternate 0,1,0,1 and pulse fim_varredura on every step.
REQ-023 posicao SHALL never leave the range 0..POS_MAX; no wrap-around.
REQ-024 ligar=0 sampled in any state SHALL force PARADO on the next edge, aborting the current step; posicao and sentido SHALL hold; pulses SHALL not fire in that cycle.
REQ-025 When ligar=0 and medida_pronta=1 occur in the same ESPERA cycle, ligar SHALL take priority: the FSM goes to PARADO and posicao is not advanced.
REQ-026 Re-enabling SHALL resume from the held posicao and sentido, starting with a full ASSENTA.
REQ-027 medir, fim_varredura and erro_medida SHALL be registered, glitch-free, and SHALL never be high for two consecutive cycles.
REQ-028 Internal counters SHALL be 32-bit unsigned and SHALL saturate, never wrap.

Reset
REQ-029 While reset=0, the outputs SHALL be: state=PARADO, posicao=0, sentido=1, medir=0, fim_varredura=0, erro_medida=0, db_estado=0, and all counters 0.
REQ-030 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge; after release, operation SHALL restart from REQ-029 values.

Configuration
REQ-031 With macro TIMEOUT_MEDIDA_EN defined, ESPERA SHALL count cycles; if count reaches T_TIMEOUT-1 without medida_pronta, the FSM SHALL pulse erro_medida and go to AVANCA.
REQ-032 If medida_pronta arrives on the same cycle as the timeout, the FSM SHALL treat it as a normal acknowledge and SHALL NOT pulse erro_medida.
REQ-033 Without TIMEOUT_MEDIDA_EN, ESPERA SHALL wait indefinitely, erro_medida SHALL be constant 0, and the timeout counter SHALL not be synthesized.

Verification
REQ-034 Bench parameters: T_ASSENTA=4, POS_MAX=3, T_TIMEOUT=6. Scenario: hold ligar=1 and ack each medir 2 cycles later -> posicao sequence 0,1,2,3,2,1,0,1; fim_varredura pulses at 3 and at 0; 4 cycles between AVANCA and medir.
REQ-035 Scenario: drop ligar during ASSENTA at posicao=2 -> PARADO next edge, posicao=2 held; re-raise ligar -> 4 settle cycles, then medir, with posicao still 2.
REQ-036 Scenario: TIMEOUT_MEDIDA_EN defined, never ack -> erro_medida pulses 6 cycles after entering ESPERA, and posicao advances by 1; without the macro -> FSM stays in ESPERA for 100 cycles, erro_medida=0.
REQ-037 Scenario: pulse reset low mid-ESPERA at posicao=3 -> outputs go to REQ-029 values asynchronously, before the next edge.
REQ-038 Scenario: medida_pronta held high continuously -> exactly one medir and one advance per step; no double advance.
REQ-039 Scenario: medida_pronta coincides with timeout -> no erro_medida; advance occurs.
